// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle add/sub/and/or, 32-step shift-add multiply.
// Define ALU_SEQ_FAST_MUL_EN to make multiply single-cycle (busy_o stays 0).
module alu_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic [2:0]  ALU_Ctrl_i,
  output logic [31:0] data_o,
  output logic        zero_o,
  output logic        done_o,
  output logic        busy_o
);

  // state | meaning
  // IDLE  | accepting requests; single-cycle ops complete here
  // MUL   | iterative multiply running, one shift-add step per cycle
  typedef enum logic {IDLE, MUL} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;

  logic [31:0] quick_res;
  logic [31:0] step_acc;

  always_comb begin
    quick_res = 32'd0;
    case (ALU_Ctrl_i)
      3'b000:  quick_res = data1_i + data2_i;
      3'b010:  quick_res = data1_i - data2_i;
      3'b100:  quick_res = data1_i & data2_i;
      3'b101:  quick_res = data1_i | data2_i;
`ifdef ALU_SEQ_FAST_MUL_EN
      3'b111:  quick_res = data1_i * data2_i;
`endif
      default: quick_res = 32'd0;
    endcase
  end

  // Only the low word is kept, so the multiplicand can be truncated as it shifts.
  assign step_acc = acc_q + (mplr_q[0] ? mcand_q : 32'd0);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
`ifndef ALU_SEQ_FAST_MUL_EN
          if (ALU_Ctrl_i == 3'b111) begin
            mcand_d = data1_i;
            mplr_d  = data2_i;
            acc_d   = 32'd0;
            cnt_d   = 6'd32;
            busy_d  = 1'b1;
            state_d = MUL;
          end else
`endif
          begin
            data_d = quick_res;
            zero_d = (quick_res == 32'd0);
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d   = step_acc;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          data_d  = step_acc;
          zero_d  = (step_acc == 32'd0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      data_q  <= 32'd0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 6'd0;
      acc_q   <= 32'd0;
      mcand_q <= 32'd0;
      mplr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
    end
  end

  assign data_o = data_q;
  assign zero_o = zero_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued at issue, compared at done_o.
module tb_alu_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [2:0]  ALU_Ctrl_i;
  logic [31:0] data_o;
  logic        zero_o;
  logic        done_o;
  logic        busy_o;

  alu_seq dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .ALU_Ctrl_i (ALU_Ctrl_i),
    .data_o     (data_o),
    .zero_o     (zero_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 32;
`endif

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    case (op)
      3'b000:  e.data = a + b;
      3'b010:  e.data = a - b;
      3'b100:  e.data = a & b;
      3'b101:  e.data = a | b;
      3'b111:  e.data = a * b;
      default: e.data = 32'd0;
    endcase
    e.zero = (e.data == 32'd0);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i    = 1'b1;
    ALU_Ctrl_i = op;
    data1_i    = a;
    data2_i    = b;
    sb_q.push_back(model(op, a, b));
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_done(output bit got, output int busy_cnt, output int lat);
    got = 1'b0;
    busy_cnt = 0;
    lat = 1;
    while (!got && lat < 60) begin
      if (done_o) got = 1'b1;
      else begin
        if (busy_o) busy_cnt++;
        @(posedge clk_i); #1;
        lat++;
      end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got done_o with no expected result queued");
      e = '0;
    end else e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    valid_i = 1'b1;
    ALU_Ctrl_i = 3'b000;
    data1_i = 32'd1;
    data2_i = 32'd1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({data_o, zero_o, done_o, busy_o} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_in: data=%h zero=%b done=%b busy=%b, required 0/1/0/0", data_o, zero_o, done_o, busy_o);
    end
    rst_i = 1'b1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if ({data_o, zero_o, done_o, busy_o} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_out: data=%h zero=%b done=%b busy=%b, required 0/1/0/0", data_o, zero_o, done_o, busy_o);
    end
  endtask

  task automatic test_single_cycle();
    logic [2:0]  ops [6] = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b101, 3'b010};
    logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'd5, 32'h12345678, 32'hF0F0_1234, 32'h0000_8001, 32'd9};
    logic [31:0] bs  [6] = '{32'd1, 32'd7, 32'h11111111, 32'h0FF0_FF00, 32'h1000_0010, 32'd9};
    bit got; int bc; int lat; exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(got, bc, lat);
      pop_exp(e);
      checks++;
      if (!got || lat != 1) begin
        failures++;
        $display("FAIL single_latency[%0d]: got=%0d lat=%0d, required latency 1", i, got, lat);
      end
      checks++;
      if ({data_o, zero_o} !== {e.data, e.zero}) begin
        failures++;
        $display("FAIL single_result[%0d]: data=%h zero=%b, required %h/%b", i, data_o, zero_o, e.data, e.zero);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if ({done_o, data_o, zero_o} !== {1'b0, 32'd0, 1'b1}) begin
        failures++;
        $display("FAIL idle_hold[%0d]: done=%b data=%h zero=%b, required 0/00000000/1", i, done_o, data_o, zero_o);
      end
    end
  endtask

  task automatic test_mul();
    bit got; int bc; int lat; int pre_busy = 0; int pre = 0; exp_t e;
    issue(3'b111, 32'd12345, 32'd6789);
`ifndef ALU_SEQ_FAST_MUL_EN
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; ALU_Ctrl_i = 3'b000; data1_i = 32'd1; data2_i = 32'd1;
      if (busy_o) pre_busy++;
      checks++;
      if (done_o !== 1'b0) begin
        failures++;
        $display("FAIL mul_early_done[%0d]: done=%b, required 0", i, done_o);
      end
      @(posedge clk_i); #1;
      pre++;
    end
    valid_i = 1'b0;
`endif
    wait_done(got, bc, lat);
    pop_exp(e);
    checks++;
    if (!got || (lat + pre) != MUL_LAT || (bc + pre_busy) != MUL_BUSY) begin
      failures++;
      $display("FAIL mul_timing: got=%0d lat=%0d busy=%0d, required lat %0d busy %0d", got, lat + pre, bc + pre_busy, MUL_LAT, MUL_BUSY);
    end
    checks++;
    if ({data_o, zero_o} !== {32'h04FED79D, 1'b0} || data_o !== e.data) begin
      failures++;
      $display("FAIL mul_result: data=%h zero=%b, required 04fed79d/0", data_o, zero_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if ({done_o, busy_o, data_o} !== {1'b0, 1'b0, 32'h04FED79D}) begin
      failures++;
      $display("FAIL mul_after: done=%b busy=%b data=%h, required 0/0/04fed79d", done_o, busy_o, data_o);
    end
  endtask

  task automatic test_mul_small();
    bit got; int bc; int lat; exp_t e;
    issue(3'b111, 32'd7, 32'd6);
    wait_done(got, bc, lat);
    pop_exp(e);
    checks++;
    if (!got || lat != MUL_LAT || bc != MUL_BUSY || data_o !== 32'd42 || data_o !== e.data) begin
      failures++;
      $display("FAIL mul_small: got=%0d lat=%0d busy=%0d data=%h, required lat %0d busy %0d data 0000002a", got, lat, bc, data_o, MUL_LAT, MUL_BUSY);
    end
  endtask

  task automatic test_back_to_back();
    bit got; int bc; int lat; exp_t e;
    issue(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(got, bc, lat);
    pop_exp(e);
    checks++;
    if (!got || data_o !== 32'h00000001 || zero_o !== 1'b0 || data_o !== e.data) begin
      failures++;
      $display("FAIL b2b_mul: got=%0d data=%h zero=%b, required 00000001/0", got, data_o, zero_o);
    end
    issue(3'b101, 32'h000000F0, 32'h0000000F);
    pop_exp(e);
    checks++;
    if ({done_o, data_o, zero_o} !== {1'b1, 32'h000000FF, 1'b0} || data_o !== e.data) begin
      failures++;
      $display("FAIL b2b_or: done=%b data=%h zero=%b, required 1/000000ff/0", done_o, data_o, zero_o);
    end
  endtask

  task automatic test_undefined();
    logic [2:0] ops [3] = '{3'b001, 3'b011, 3'b110};
    bit got; int bc; int lat; exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'h0000_0103, 32'h0000_0044);
      wait_done(got, bc, lat);
      pop_exp(e);
      checks++;
      if (!got || lat != 1 || {data_o, zero_o} !== {32'd0, 1'b1} || e.zero !== 1'b1) begin
        failures++;
        $display("FAIL undefined_op[%0d]: got=%0d lat=%0d data=%h zero=%b, required lat 1 data 0 zero 1", i, got, lat, data_o, zero_o);
      end
      issue(3'b000, 32'd2, 32'd3);
      pop_exp(e);
    end
  endtask

  task automatic test_reset_abort();
    bit got; int bc; int lat; int dones = 0; exp_t e;
`ifndef ALU_SEQ_FAST_MUL_EN
    issue(3'b111, 32'd12345, 32'd6789);
    repeat (9) begin @(posedge clk_i); #1; end
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_before: busy=%b, required 1", busy_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    sb_q.delete();
    checks++;
    if ({busy_o, done_o, data_o, zero_o} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL abort_reset: busy=%b done=%b data=%h zero=%b, required 0/0/0/1", busy_o, done_o, data_o, zero_o);
    end
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done: active cycles=%0d, required 0", dones);
    end
`endif
    issue(3'b100, 32'h0000000C, 32'h0000000A);
    wait_done(got, bc, lat);
    pop_exp(e);
    checks++;
    if (!got || lat != 1 || data_o !== 32'h00000008 || data_o !== e.data) begin
      failures++;
      $display("FAIL abort_then_and: got=%0d lat=%0d data=%h, required lat 1 data 00000008", got, lat, data_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b0;
    valid_i = 1'b0;
    ALU_Ctrl_i = 3'b000;
    data1_i = 32'd0;
    data2_i = 32'd0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_mul_small();
    test_back_to_back();
    test_undefined();
    test_reset_abort();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: pending=%0d, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
